// File: rtl/osd_ctm_event_packetizer.sv
// Control-transfer event packetizer: timestamps call/return events, buffers them and
// serialises each as a 10-flit DII event packet. OSD_CTM_EVENT_OVERFLOW_EN adds drop counting and overflow packets.
package osd_dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_ctm_event_packetizer
  import osd_dii_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  id,
  input  logic [15:0] event_dest,
  input  logic        enable,
  input  logic        ev_valid,
  input  logic [31:0] ev_pc,
  input  logic [31:0] ev_npc,
  input  logic        ev_call,
  input  logic        ev_ret,
  output dii_flit     debug_out,
  input  logic        debug_out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        ret;
    logic        call;
  } ev_t;

  typedef enum logic [1:0] {IDLE, SEND_EV, SEND_OVF} state_t;

  // Handshake: a flit transfers on a cycle where debug_out.valid && debug_out_ready;
  // once valid rises the flit is held unchanged until that transfer happens.

  logic [31:0]   ts_q;
  ev_t           mem [FIFO_DEPTH];
  ev_t           head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state, state_next;
  logic [3:0]    idx, idx_d;
  dii_flit       out_q, out_d;
  logic          capture, full, empty, accept, pop, push, load;
  logic          ovf_pending;
  logic [15:0]   ovf_word;

  assign debug_out = out_q;
  assign head      = mem[rd_ptr];
  assign capture   = enable && ev_valid && (ev_call || ev_ret);
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign accept    = out_q.valid && debug_out_ready;
  assign pop       = (state == SEND_EV) && accept && out_q.last;
  // A full FIFO still takes the event when its head leaves in the same cycle.
  assign push      = capture && (!full || pop);
  assign load      = !out_q.valid || accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ts: ts_q, npc: ev_npc, pc: ev_pc, ret: ev_ret, call: ev_call};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef OSD_CTM_EVENT_OVERFLOW_EN
  logic [15:0] drop_cnt, ovf_snap;
  logic        drop, ovf_start;

  assign drop        = capture && !push;
  assign ovf_start   = (state == IDLE) && (state_next == SEND_OVF);
  assign ovf_pending = (drop_cnt != 16'd0);
  assign ovf_word    = ovf_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ovf_snap <= '0;
    end else if (ovf_start) begin
      ovf_snap <= drop_cnt;
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign ovf_pending = 1'b0;
  assign ovf_word    = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      out_q <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        idx   <= idx_d;
        out_q <= out_d;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ovf_pending)  state_next = SEND_OVF;
        else if (!empty)  state_next = SEND_EV;
      end
      SEND_EV, SEND_OVF: begin
        if (accept && out_q.last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Builds the flit to register next; only used when the output register loads.
  always_comb begin
    idx_d = '0;
    out_d = '0;
    if (state_next == SEND_EV || state_next == SEND_OVF) begin
      idx_d = (state == IDLE) ? 4'd0 : idx + 4'd1;
      out_d.valid = 1'b1;
      if (state_next == SEND_EV) begin
        out_d.last = (idx_d == 4'd9);
        case (idx_d)
          4'd0:    out_d.data = event_dest;
          4'd1:    out_d.data = {6'b0, id};
          4'd2:    out_d.data = 16'h8000;
          4'd3:    out_d.data = head.ts[15:0];
          4'd4:    out_d.data = head.ts[31:16];
          4'd5:    out_d.data = head.npc[15:0];
          4'd6:    out_d.data = head.npc[31:16];
          4'd7:    out_d.data = head.pc[15:0];
          4'd8:    out_d.data = head.pc[31:16];
          default: out_d.data = {14'b0, head.ret, head.call};
        endcase
      end else begin
        out_d.last = (idx_d == 4'd3);
        case (idx_d)
          4'd0:    out_d.data = event_dest;
          4'd1:    out_d.data = {6'b0, id};
          4'd2:    out_d.data = 16'h8400;
          default: out_d.data = ovf_word;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osd_ctm_event_packetizer.sv
// Bench for osd_ctm_event_packetizer: directed scenarios plus random traffic,
// scored flit-by-flit against packets built from captured events.
module tb_osd_ctm_event_packetizer;
  import osd_dii_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  id;
  logic [15:0] event_dest;
  logic        enable, ev_valid, ev_call, ev_ret, debug_out_ready;
  logic [31:0] ev_pc, ev_npc;
  dii_flit     debug_out;

  osd_ctm_event_packetizer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .id(id), .event_dest(event_dest), .enable(enable),
    .ev_valid(ev_valid), .ev_pc(ev_pc), .ev_npc(ev_npc), .ev_call(ev_call), .ev_ret(ev_ret),
    .debug_out(debug_out), .debug_out_ready(debug_out_ready)
  );

  // model of the free-running timestamp: cycles since reset plus an offset
  logic [31:0] cyc;
  logic [31:0] ts_off;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  // ---------------- scoreboard state ----------------
  int n_cmp, n_bad, extra, ev_pushed, ev_done;
  logic [17:0] exp_q[$];   // {event packet end, last, data}
  logic        hold_pend;
  logic [16:0] hold_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ts_now();
    return cyc + ts_off;
  endfunction

  task automatic push_event(input logic [31:0] ts, pc, npc, input logic ret, call);
    logic [15:0] w [10];
    w[0] = event_dest;   w[1] = {6'b0, id};    w[2] = 16'h8000;
    w[3] = ts[15:0];     w[4] = ts[31:16];     w[5] = npc[15:0];
    w[6] = npc[31:16];   w[7] = pc[15:0];      w[8] = pc[31:16];
    w[9] = {14'b0, ret, call};
    for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), (i == 9), w[i]});
    ev_pushed++;
  endtask

`ifdef OSD_CTM_EVENT_OVERFLOW_EN
  task automatic push_ovf(input logic [15:0] cnt);
    exp_q.push_back({2'b00, event_dest});
    exp_q.push_back({2'b00, 6'b0, id});
    exp_q.push_back({2'b00, 16'h8400});
    exp_q.push_back({2'b01, cnt});
  endtask
`endif

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(debug_out.valid), 32'd1);
        check("hold_word", 32'({debug_out.last, debug_out.data}), 32'(hold_word));
      end
      hold_pend = debug_out.valid && !debug_out_ready;
      hold_word = {debug_out.last, debug_out.data};
      if (debug_out.valid && debug_out_ready) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          e = exp_q.pop_front();
          check("flit", 32'({debug_out.last, debug_out.data}), 32'(e[16:0]));
          if (e[17]) ev_done++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic ret, call, output logic [31:0] pc, npc);
    pc = $urandom;
    npc = $urandom;
    ev_pc = pc; ev_npc = npc; ev_ret = ret; ev_call = call; ev_valid = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || debug_out.valid) && n < 3000) begin
      step();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t, p, n;
    logic [31:0] tss [6];
    logic [31:0] pcs [6];
    logic [31:0] npcs [6];
    logic r, k;
    int guard;

    rst_n = 1'b0; enable = 1'b1; ev_valid = 1'b0; ev_call = 1'b0; ev_ret = 1'b0;
    ev_pc = '0; ev_npc = '0; debug_out_ready = 1'b1; ts_off = '0;
    id = 10'($urandom); event_dest = 16'($urandom);
    #1;
    check("rst_valid", 32'(debug_out.valid), 32'd0);
    check("rst_last", 32'(debug_out.last), 32'd0);
    check("rst_data", 32'(debug_out.data), 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    // single call captured at timestamp 5, flit 0 two cycles later
    guard = 0;
    while (cyc != 32'd5 && guard < 20) begin step(); guard++; end
    ev_pc = 32'h1000; ev_npc = 32'h2000; ev_call = 1'b1; ev_ret = 1'b0; ev_valid = 1'b1;
    push_event(32'h5, 32'h1000, 32'h2000, 1'b0, 1'b1);
    @(negedge clk) check("lat_cycle_n", 32'(debug_out.valid), 32'd0);
    step(); ev_valid = 1'b0; ev_call = 1'b0;
    @(negedge clk) check("lat_cycle_n1", 32'(debug_out.valid), 32'd0);
    @(negedge clk) check("lat_cycle_n2", 32'(debug_out.valid), 32'd1);
    check("lat_flit0", 32'(debug_out.data), 32'(event_dest));
    drain();

    // backpressure: ready toggles every cycle
    debug_out_ready = 1'b0;
    fire(1'b1, 1'b0, p, n);
    push_event(ts_now(), p, n, 1'b1, 1'b0);
    step(); ev_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      debug_out_ready = ~debug_out_ready;
      step();
    end
    debug_out_ready = 1'b1;
    drain();

    // random traffic, never offering an event to a full FIFO
    for (int c = 0; c < 400; c++) begin
      debug_out_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      r = 1'($urandom_range(0, 1));
      k = 1'($urandom_range(0, 1));
      fire(r, k, p, n);
      ev_valid = ($urandom_range(0, 2) == 0);
      if (ev_valid && enable && (r || k)) begin
        if (ev_pushed - ev_done < DEPTH) push_event(ts_now(), p, n, r, k);
        else ev_valid = 1'b0;
      end
      step();
    end
    ev_valid = 1'b0; enable = 1'b1; debug_out_ready = 1'b1;
    drain();

    // FIFO full: 6 back-to-back events with the sink stalled
    debug_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fire(1'b0, 1'b1, p, n);
      tss[i] = ts_now(); pcs[i] = p; npcs[i] = n;
      step();
    end
    ev_valid = 1'b0;
    // event 1 is already in flight when the drops happen, so it leaves first
    push_event(tss[0], pcs[0], npcs[0], 1'b0, 1'b1);
`ifdef OSD_CTM_EVENT_OVERFLOW_EN
    push_ovf(16'd2);
`endif
    for (int i = 1; i < 4; i++) push_event(tss[i], pcs[i], npcs[i], 1'b0, 1'b1);
    repeat (5) step();
    debug_out_ready = 1'b1;
    drain();

    // push into a full FIFO in the cycle its head is popped
    debug_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fire(1'b1, 1'b0, p, n);
      push_event(ts_now(), p, n, 1'b1, 1'b0);
      step();
    end
    ev_valid = 1'b0;
    repeat (4) step();
    debug_out_ready = 1'b1;
    repeat (9) step();
    fire(1'b0, 1'b1, p, n);
    push_event(ts_now(), p, n, 1'b0, 1'b1);
    step(); ev_valid = 1'b0;
    drain();

    // timestamp wrap
    force dut.ts_q = 32'hFFFFFFFE;
    ts_off = 32'hFFFFFFFE - cyc;
    #1;
    release dut.ts_q;
    step();
    fire(1'b0, 1'b1, p, n);
    push_event(32'hFFFFFFFF, p, n, 1'b0, 1'b1);
    step(); ev_valid = 1'b0;
    step();
    fire(1'b1, 1'b0, p, n);
    push_event(32'h00000001, p, n, 1'b1, 1'b0);
    step(); ev_valid = 1'b0;
    drain();

    // reset while flit 5 of a packet is waiting
    debug_out_ready = 1'b0;
    fire(1'b1, 1'b0, p, n);
    push_event(ts_now(), p, n, 1'b1, 1'b0);
    step(); ev_valid = 1'b0;
    repeat (3) step();
    debug_out_ready = 1'b1;
    repeat (5) step();
    debug_out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(debug_out.valid), 32'd0);
    check("midrst_last", 32'(debug_out.last), 32'd0);
    check("midrst_data", 32'(debug_out.data), 32'd0);
    check("midrst_left", exp_q.size(), 5);
    exp_q.delete();
    ts_off = '0;
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    step();
    debug_out_ready = 1'b1;
    fire(1'b0, 1'b1, p, n);
    push_event(ts_now(), p, n, 1'b0, 1'b1);
    step(); ev_valid = 1'b0;
    drain();

    // ---------------- report ----------------
    check("extra_flits", extra, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
